dmem_responder: RTL and testbench

Data-memory responder serving the CPU core's memory-stage load/store requests. It is the memory end of the core's data port. It accepts one request at a time under a valid/ready handshake and applies byte/half/word lane steering on stores. On loads it applies sign or zero extension. It flags misaligned accesses as AdEL/AdES for CP0 and holds the pipeline through a stall output until the response returns.

---
 rtl/mem_pkg.sv | 49 ++++
 rtl/dmem_ram_sp.sv | 31 +++
 rtl/dmem_responder.sv | 166 ++++++++++++++++
 tb/tb_dmem_responder.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared data-memory definitions: access codes, responder states and the
// address-error cause codes also used by CP0.
package mem_pkg;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  localparam logic [5:0] EXC_ADEL = 6'h04;
  localparam logic [5:0] EXC_ADES = 6'h05;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP,
    ERR
  } state_e;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } size_e;

  // Reserved codes fall through to word accesses.
  function automatic size_e op_size(input logic [2:0] op);
    size_e sz;
    case (op)
      MEM_B, MEM_BU: sz = SZ_B;
      MEM_H, MEM_HU: sz = SZ_H;
      MEM_W:         sz = SZ_W;
      default:       sz = SZ_W;
    endcase
    return sz;
  endfunction

  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] lsb);
    logic bad;
    case (op_size(op))
      SZ_H:    bad = lsb[0];
      SZ_W:    bad = (lsb != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_ram_sp.sv
// Single-port 2^ADDR_W x 32 RAM, byte-enabled write, synchronous read.
module dmem_ram_sp #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [3:0]        be_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [2**ADDR_W];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int unsigned i = 0; i < 4; i++) begin
          if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Memory-stage data port responder: handshake FSM, store lane steering,
// load extension and AdEL/AdES reporting around a single-port RAM.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        adel,
  output logic        ades,
  output logic [31:0] bad_addr,
  output logic        stall
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hold_q, hold_d;

  logic        ram_en;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] ld_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        ld_signed;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    ram_be    = 4'b1111;
    ram_wdata = wdata_q;
    case (op_size(op_q))
      SZ_B: begin
        ram_be    = 4'b0001 << addr_q[1:0];
        ram_wdata = {4{wdata_q[7:0]}};
      end
      SZ_H: begin
        ram_be    = addr_q[1] ? 4'b1100 : 4'b0011;
        ram_wdata = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte   = ram_rdata[{addr_q[1:0], 3'b000} +: 8];
    ld_half   = ram_rdata[{addr_q[1], 4'b0000} +: 16];
    ld_signed = ~op_q[2];
    case (op_size(op_q))
      SZ_B:    ld_data = {{24{ld_signed & ld_byte[7]}}, ld_byte};
      SZ_H:    ld_data = {{16{ld_signed & ld_half[15]}}, ld_half};
      default: ld_data = ram_rdata;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    hold_d     = hold_q;
    ram_en     = 1'b0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    adel       = 1'b0;
    ades       = 1'b0;
    stall      = 1'b0;
    resp_rdata = hold_q;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        stall     = req_valid;
        if (req_valid) begin
          we_d    = req_we;
          op_d    = req_op;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (misaligned(req_op, req_addr[1:0])) begin
            state_d = ERR;
          end else begin
            state_d = ACCESS;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      ACCESS: begin
        stall = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          ram_en  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = we_q ? '0 : ld_data;
        hold_d     = resp_rdata;
        state_d    = IDLE;
      end
      ERR: begin
        stall      = 1'b1;
        resp_valid = 1'b1;
        adel       = ~we_q;
        ades       = we_q;
        resp_rdata = '0;
        hold_d     = '0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bad_addr = addr_q;

  // Reset on the write edge must suppress the store, so gate the enable here.
  dmem_ram_sp #(
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk_i  (clk),
    .en_i   (ram_en & ~rst),
    .we_i   (we_q),
    .be_i   (ram_be),
    .addr_i (addr_q[ADDR_W+1:2]),
    .wdata_i(ram_wdata),
    .rdata_o(ram_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, reset corner cases and a
// randomized run against a word-array memory model, at WAIT_CYCLES 0 and 3.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst        [2];
  logic        req_valid  [2];
  logic        req_we     [2];
  logic [2:0]  req_op     [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        req_ready  [2];
  logic        resp_valid [2];
  logic [31:0] resp_rdata [2];
  logic        adel       [2];
  logic        ades       [2];
  logic [31:0] bad_addr   [2];
  logic        stall      [2];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    dmem_responder #(
      .ADDR_W(10),
      .WAIT_CYCLES(g == 0 ? 0 : 3)
    ) u_dut (
      .clk       (clk),
      .rst       (rst[g]),
      .req_valid (req_valid[g]),
      .req_we    (req_we[g]),
      .req_op    (req_op[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .req_ready (req_ready[g]),
      .resp_valid(resp_valid[g]),
      .resp_rdata(resp_rdata[g]),
      .adel      (adel[g]),
      .ades      (ades[g]),
      .bad_addr  (bad_addr[g]),
      .stall     (stall[g])
    );
  end

  typedef struct {
    logic        we;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic        adel;
    logic        ades;
  } vec_t;

  vec_t tbl[$];
  logic [31:0] mdl [16];

  function automatic int wc(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input logic we, input logic [2:0] op, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] rd,
                     input logic ae_l, input logic ae_s);
    vec_t v;
    v.we = we; v.op = op; v.addr = addr; v.wdata = wdata;
    v.rd = rd; v.adel = ae_l; v.ades = ae_s;
    tbl.push_back(v);
  endtask

  // One complete transaction: present, accept, then wait for the response.
  task automatic xact(input int d, input logic we, input logic [2:0] op,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rd, input logic exp_adel,
                      input logic exp_ades, input string tag);
    int lat;
    int exp_lat;
    bit got;
    exp_lat = (exp_adel | exp_ades) ? 1 : 2 + wc(d);
    @(negedge clk);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_op[d]    = op;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    #1;
    chk({tag, " ready"}, 32'(req_ready[d]), 32'd1);
    chk({tag, " idle_resp"}, 32'(resp_valid[d]), 32'd0);
    chk({tag, " idle_stall"}, 32'(stall[d]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid[d] = 1'b0;
    req_addr[d]  = ~addr;
    req_wdata[d] = $urandom;
    req_we[d]    = ~we;
    lat = 1;
    got = 1'b0;
    while (!got && lat <= 40) begin
      #1;
      if (resp_valid[d]) begin
        got = 1'b1;
      end else begin
        chk({tag, " wait_stall"}, 32'(stall[d]), 32'd1);
        chk({tag, " wait_ready"}, 32'(req_ready[d]), 32'd0);
        lat++;
        @(negedge clk);
      end
    end
    if (!got) begin
      chk({tag, " timeout"}, 32'd0, 32'd1);
    end else begin
      chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, " rdata"}, resp_rdata[d], exp_rd);
      chk({tag, " adel"}, 32'(adel[d]), 32'(exp_adel));
      chk({tag, " ades"}, 32'(ades[d]), 32'(exp_ades));
      chk({tag, " resp_stall"}, 32'(stall[d]), 32'(exp_adel | exp_ades));
      if (exp_adel | exp_ades) chk({tag, " bad_addr"}, bad_addr[d], addr);
    end
  endtask

  task automatic model_op(input logic we, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd,
                          output logic e_l, output logic e_s);
    int sh;
    int bytes;
    logic [31:0] mask;
    logic [31:0] v;
    bit err;
    bytes = (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
    err = (a % bytes) != 0;
    e_l = err & ~we;
    e_s = err & we;
    rd = 32'd0;
    if (!err) begin
      sh = 8 * int'(a[1:0]);
      mask = (bytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * bytes)) - 1);
      if (we) begin
        mdl[a[5:2]] = (mdl[a[5:2]] & ~(mask << sh)) | ((wd & mask) << sh);
      end else begin
        v = (mdl[a[5:2]] >> sh) & mask;
        if (!op[2] && bytes < 4 && v[8*bytes-1]) v = v | ~mask;
        rd = v;
      end
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        el;
    logic        es;
    logic [31:0] a;
    logic [31:0] wd;
    logic        we;
    logic [2:0]  op;

    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      req_valid[d] = 1'b0;
      req_we[d] = 1'b0;
      req_op[d] = 3'b010;
      req_addr[d] = '0;
      req_wdata[d] = '0;
    end
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b1;
    req_addr[0]  = 32'h30;
    req_wdata[0] = 32'h5A5A_5A5A;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("rst%0d ready", d), 32'(req_ready[d]), 32'd1);
        chk($sformatf("rst%0d resp_valid", d), 32'(resp_valid[d]), 32'd0);
        chk($sformatf("rst%0d stall", d), 32'(stall[d]), (d == 0) ? 32'd1 : 32'd0);
        chk($sformatf("rst%0d rdata", d), resp_rdata[d], 32'd0);
        chk($sformatf("rst%0d adel_ades", d), 32'({adel[d], ades[d]}), 32'd0);
        chk($sformatf("rst%0d bad_addr", d), bad_addr[d], 32'd0);
      end
    end
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);
    #1;
    req_valid[0] = 1'b0;
    chk("first accept access_ready", 32'(req_ready[0]), 32'd0);
    chk("first accept access_stall", 32'(stall[0]), 32'd1);
    chk("first accept access_resp", 32'(resp_valid[0]), 32'd0);
    @(negedge clk);
    #1;
    chk("first accept resp_valid", 32'(resp_valid[0]), 32'd1);
    chk("first accept resp_stall", 32'(stall[0]), 32'd0);

    add(1, 3'b010, 32'h10,   32'hDEAD_BEEF, 32'h0,         0, 0);
    add(0, 3'b010, 32'h30,   32'h0,         32'h5A5A_5A5A, 0, 0);
    add(0, 3'b010, 32'h10,   32'h0,         32'hDEAD_BEEF, 0, 0);
    add(1, 3'b000, 32'h13,   32'h0000_0080, 32'h0,         0, 0);
    add(0, 3'b000, 32'h13,   32'h0,         32'hFFFF_FF80, 0, 0);
    add(0, 3'b100, 32'h13,   32'h0,         32'h0000_0080, 0, 0);
    add(0, 3'b010, 32'h10,   32'h0,         32'h80AD_BEEF, 0, 0);
    add(1, 3'b010, 32'h20,   32'h1122_3344, 32'h0,         0, 0);
    add(1, 3'b001, 32'h22,   32'h0000_8001, 32'h0,         0, 0);
    add(0, 3'b001, 32'h22,   32'h0,         32'hFFFF_8001, 0, 0);
    add(0, 3'b101, 32'h22,   32'h0,         32'h0000_8001, 0, 0);
    add(0, 3'b010, 32'h20,   32'h0,         32'h8001_3344, 0, 0);
    add(1, 3'b100, 32'h21,   32'hFFFF_FF7F, 32'h0,         0, 0);
    add(0, 3'b000, 32'h21,   32'h0,         32'h0000_007F, 0, 0);
    add(0, 3'b010, 32'h20,   32'h0,         32'h8001_7F44, 0, 0);
    add(1, 3'b010, 32'h100,  32'hCAFE_F00D, 32'h0,         0, 0);
    add(0, 3'b010, 32'h102,  32'h0,         32'h0,         1, 0);
    add(1, 3'b001, 32'h101,  32'h0000_BEEF, 32'h0,         0, 1);
    add(0, 3'b010, 32'h100,  32'h0,         32'hCAFE_F00D, 0, 0);
    add(0, 3'b001, 32'h103,  32'h0,         32'h0,         1, 0);
    add(1, 3'b010, 32'h101,  32'h1111_1111, 32'h0,         0, 1);
    add(0, 3'b010, 32'h100,  32'h0,         32'hCAFE_F00D, 0, 0);
    add(0, 3'b000, 32'h103,  32'h0,         32'hFFFF_FFCA, 0, 0);
    add(0, 3'b101, 32'h102,  32'h0,         32'h0000_CAFE, 0, 0);
    add(0, 3'b010, 32'h1010, 32'h0,         32'h80AD_BEEF, 0, 0);
    add(0, 3'b011, 32'h20,   32'h0,         32'h8001_7F44, 0, 0);
    add(0, 3'b111, 32'h10,   32'h0,         32'h80AD_BEEF, 0, 0);
    add(0, 3'b110, 32'h12,   32'h0,         32'h0,         1, 0);

    foreach (tbl[i]) begin
      xact(0, tbl[i].we, tbl[i].op, tbl[i].addr, tbl[i].wdata,
           tbl[i].rd, tbl[i].adel, tbl[i].ades, $sformatf("vec%0d", i));
    end

    // Reset during ACCESS before the write edge: store dropped, no response.
    xact(1, 1, 3'b010, 32'h40, 32'hAAAA_5555, 32'h0, 0, 0, "w3 init");
    @(negedge clk);
    req_valid[1] = 1'b1;
    req_we[1]    = 1'b1;
    req_op[1]    = 3'b010;
    req_addr[1]  = 32'h40;
    req_wdata[1] = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(negedge clk);
    rst[1] = 1'b1;
    @(negedge clk);
    #1;
    chk("w3 abort resp_valid", 32'(resp_valid[1]), 32'd0);
    chk("w3 abort ready", 32'(req_ready[1]), 32'd1);
    chk("w3 abort stall", 32'(stall[1]), 32'd0);
    rst[1] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      chk("w3 abort no_resp", 32'(resp_valid[1]), 32'd0);
    end
    xact(1, 0, 3'b010, 32'h40, 32'h0, 32'hAAAA_5555, 0, 0, "w3 reload");

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) begin
        wd = $urandom;
        a  = 32'(i * 4);
        model_op(1, 3'b010, a, wd, rd, el, es);
        xact(d, 1, 3'b010, a, wd, rd, el, es, $sformatf("init%0d_%0d", d, i));
      end
      for (int i = 0; i < 120; i++) begin
        we = 1'($urandom_range(0, 1));
        op = 3'($urandom_range(0, 7));
        a  = {$urandom_range(0, 32'hFFFFF), 6'b000000, 6'($urandom_range(0, 63))};
        wd = $urandom;
        model_op(we, op, a, wd, rd, el, es);
        xact(d, we, op, a, wd, rd, el, es, $sformatf("rnd%0d_%0d", d, i));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
